// File: rtl/hsi_obi_fetch_master.sv
// OBI read initiator that streams two 16-bit-sample spectral vectors into the
// HSI core's in1/in2 FIFOs, interleaving words A0,B0,A1,B1,... one read at a time.
module hsi_obi_fetch_master #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base1_i,
    input  logic [AW-1:0] base2_i,
    input  logic [15:0]   num_bands_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          req_o,
    input  logic          gnt_i,
    output logic [AW-1:0] addr_o,
    output logic          we_o,
    output logic [3:0]    be_o,
    output logic [DW-1:0] wdata_o,
    input  logic          rvalid_i,
    input  logic [DW-1:0] rdata_i,
    output logic          in1_wr_en_o,
    output logic [15:0]   in1_data_o,
    input  logic          in1_full_i,
    output logic          in2_wr_en_o,
    output logic [15:0]   in2_data_o,
    input  logic          in2_full_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        PUSH_LO = 3'd3,
        PUSH_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state_r;
    logic [AW-3:0] b1_r;
    logic [AW-3:0] b2_r;
    logic [15:0]   nb_r;
    logic [16:0]   w_r;
    logic [16:0]   k_r;
    logic          ch_r;      // 0 = vector 1 / FIFO1, 1 = vector 2 / FIFO2
    logic [31:0]   word_r;
    logic [15:0]   data_r;

    logic push_s;
    logic full_s;
    logic fire_s;
    logic last_s;
    logic advance_s;

    logic unused_s;
    assign unused_s = ^{base1_i[1:0], base2_i[1:0]};

    assign we_o       = 1'b0;
    assign be_o       = 4'b1111;
    assign wdata_o    = {DW{1'b0}};
    assign in1_data_o = data_r;
    assign in2_data_o = data_r;

    function automatic logic [AW-1:0] word_addr(input logic [AW-3:0] base, input logic [16:0] idx);
        logic [AW-3:0] sum;
        sum = base + (AW-2)'(idx);
        return {sum, 2'b00};
    endfunction

    // FIFO handshake and advance decision, decoded from state and full inputs
    always_comb begin
        push_s = (state_r == PUSH_LO) || (state_r == PUSH_HI);
        if (ch_r) begin
            full_s = in2_full_i;
        end else begin
            full_s = in1_full_i;
        end
        fire_s = push_s && !full_s;
        last_s = (k_r == (w_r - 17'd1));
        if (fire_s) begin
            in1_wr_en_o = !ch_r;
            in2_wr_en_o = ch_r;
        end else begin
            in1_wr_en_o = 1'b0;
            in2_wr_en_o = 1'b0;
        end
        // An odd band count ends the final word after its low halfword
        advance_s = fire_s && ((state_r == PUSH_HI) || (last_s && nb_r[0]));
    end

    // Transfer FSM with registered bus and status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            b1_r    <= '0;
            b2_r    <= '0;
            nb_r    <= 16'd0;
            w_r     <= 17'd0;
            k_r     <= 17'd0;
            ch_r    <= 1'b0;
            word_r  <= 32'd0;
            data_r  <= 16'd0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            req_o   <= 1'b0;
            addr_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        b1_r   <= base1_i[AW-1:2];
                        b2_r   <= base2_i[AW-1:2];
                        nb_r   <= num_bands_i;
                        w_r    <= ({1'b0, num_bands_i} + 17'd1) >> 1;
                        k_r    <= 17'd0;
                        ch_r   <= 1'b0;
                        busy_o <= 1'b1;
                        if (num_bands_i == 16'd0) begin
                            state_r <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_r <= REQ;
                            req_o   <= 1'b1;
                            addr_o  <= {base1_i[AW-1:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        req_o   <= 1'b0;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (rvalid_i) begin
                        word_r  <= rdata_i[31:0];
                        data_r  <= rdata_i[15:0];
                        state_r <= PUSH_LO;
                    end
                end
                PUSH_LO: begin
                    if (fire_s && !advance_s) begin
                        data_r  <= word_r[31:16];
                        state_r <= PUSH_HI;
                    end
                end
                PUSH_HI: begin
                    state_r <= PUSH_HI;
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            if (advance_s) begin
                if (!ch_r) begin
                    ch_r    <= 1'b1;
                    state_r <= REQ;
                    req_o   <= 1'b1;
                    addr_o  <= word_addr(b2_r, k_r);
                end else if (!last_s) begin
                    ch_r    <= 1'b0;
                    k_r     <= k_r + 17'd1;
                    state_r <= REQ;
                    req_o   <= 1'b1;
                    addr_o  <= word_addr(b1_r, k_r + 17'd1);
                end else begin
                    state_r <= DONE;
                    done_o  <= 1'b1;
                end
            end
        end
    end

endmodule
